// File: rtl/power_gate_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pg_pkg
// Shared definitions for the power-gate controller slice.
//   - 3-bit state encodings (PG_ST_*) and the matching pg_state_e enum
//   - PG_OFF / PG_ON helper constants (the two stable states)
//   - pg_iso_open(): states in which the isolation clamps are released
// Configuration macro: RETENTION_EN (the RESTORE/SAVE encodings are always
// reserved so pg_state values stay identical across both builds).
// ----------------------------------------------------------------------------
package pg_pkg;

    localparam logic [2:0] PG_ST_OFF     = 3'd0;
    localparam logic [2:0] PG_ST_PWR_UP  = 3'd1;
    localparam logic [2:0] PG_ST_RESTORE = 3'd2;
    localparam logic [2:0] PG_ST_DEISO   = 3'd3;
    localparam logic [2:0] PG_ST_ON      = 3'd4;
    localparam logic [2:0] PG_ST_ISO     = 3'd5;
    localparam logic [2:0] PG_ST_SAVE    = 3'd6;
    localparam logic [2:0] PG_ST_PWR_DN  = 3'd7;

    localparam logic [2:0] PG_OFF = PG_ST_OFF;
    localparam logic [2:0] PG_ON  = PG_ST_ON;

    typedef enum logic [2:0] {
        ST_OFF     = PG_ST_OFF,
        ST_PWR_UP  = PG_ST_PWR_UP,
        ST_RESTORE = PG_ST_RESTORE,
        ST_DEISO   = PG_ST_DEISO,
        ST_ON      = PG_ST_ON,
        ST_ISO     = PG_ST_ISO,
        ST_SAVE    = PG_ST_SAVE,
        ST_PWR_DN  = PG_ST_PWR_DN
    } pg_state_e;

    // Clamps open in DEISO and stay open through ON; every other state clamps.
    function automatic logic pg_iso_open(input pg_state_e s);
        return (s == ST_DEISO) || (s == ST_ON);
    endfunction

endpackage

// File: rtl/power_gate_ctrl_if.sv
// ----------------------------------------------------------------------------
// power_gate_ctrl_if
// Handshake and switch-control bundle between the system power manager
// (master) and the power-gate controller (slave).
//   pwr_up_req / pwr_down_req : level requests from the power manager
//   pwr_ack                   : 1-cycle completion pulse
//   sw_en_n[N_SW-1:0]         : PMOS header gate drives, 0 = conducting
//   iso_en                    : output isolation clamp enable
//   domain_on                 : domain fully powered and unclamped
//   pg_state                  : controller state (pg_pkg encoding)
//   ret_save / ret_restore    : retention strobes (only with RETENTION_EN)
// Configuration macro: RETENTION_EN adds the retention strobes.
// ----------------------------------------------------------------------------
interface power_gate_ctrl_if #(
    parameter int N_SW = 4
);
    logic            pwr_up_req;
    logic            pwr_down_req;
    logic            pwr_ack;
    logic [N_SW-1:0] sw_en_n;
    logic            iso_en;
    logic            domain_on;
    logic [2:0]      pg_state;
`ifdef RETENTION_EN
    logic            ret_save;
    logic            ret_restore;
`endif

    modport master (
        output pwr_up_req, pwr_down_req,
        input  pwr_ack, sw_en_n, iso_en, domain_on, pg_state
`ifdef RETENTION_EN
        , input ret_save, ret_restore
`endif
    );

    modport slave (
        input  pwr_up_req, pwr_down_req,
        output pwr_ack, sw_en_n, iso_en, domain_on, pg_state
`ifdef RETENTION_EN
        , output ret_save, ret_restore
`endif
    );

endinterface

// File: rtl/power_gate_ctrl_stagger.sv
// ----------------------------------------------------------------------------
// pg_stagger_seq
// Staggered header-switch enable sequencer. On start it turns on segment 0
// immediately, then one more segment every STAGGER cycles. STAGGER cycles
// after the last segment it raises done for one cycle. off switches every
// segment off at once.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start     : begin a power-up sequence (takes effect at this edge)
//   off       : open all switches (takes priority over start)
//   sw_en_n   : registered PMOS gate drives, 0 = conducting
//   done      : high in the cycle the final STAGGER interval expires
// Configuration macro: none.
// ----------------------------------------------------------------------------
module pg_stagger_seq
    import pg_pkg::*;
#(
    parameter int N_SW    = 4,
    parameter int STAGGER = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            off,
    output logic [N_SW-1:0] sw_en_n,
    output logic            done
);

    localparam int CNT_W = $clog2(STAGGER + 1);
    localparam int SEG_W = $clog2(N_SW + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGGER - 1);
    localparam logic [SEG_W-1:0] SEG_ALL  = SEG_W'(N_SW);
    localparam logic [N_SW-1:0]  ALL_OFF  = '1;
    localparam logic [N_SW-1:0]  SEG_BIT0 = N_SW'(1);

    logic             active;
    logic [CNT_W-1:0] cnt;
    // Number of segments already conducting; also the index of the next one.
    logic [SEG_W-1:0] seg;
    logic             at_last;

    assign at_last = (cnt == CNT_LAST);
    assign done    = active && at_last && (seg == SEG_ALL);

    // Segment 0 is enabled on the start edge itself, so seg begins at 1.
    // cnt counts 0..STAGGER-1 and seg stops at N_SW, so neither wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_en_n <= ALL_OFF;
            active  <= 1'b0;
            cnt     <= '0;
            seg     <= '0;
        end else if (off) begin
            sw_en_n <= ALL_OFF;
            active  <= 1'b0;
            cnt     <= '0;
            seg     <= '0;
        end else if (start) begin
            sw_en_n <= ALL_OFF << 1;
            active  <= 1'b1;
            cnt     <= '0;
            seg     <= SEG_W'(1);
        end else if (active) begin
            if (at_last) begin
                cnt <= '0;
                if (seg == SEG_ALL) begin
                    active <= 1'b0;
                end else begin
                    sw_en_n <= sw_en_n & ~(SEG_BIT0 << seg);
                    seg     <= seg + 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/power_gate_ctrl.sv
// ----------------------------------------------------------------------------
// power_gate_ctrl
// Power-gating sequencer for one switched domain. Handles the req/ack
// handshake with the system power manager, staggers header-switch turn-on
// to limit inrush, and drives the isolation clamps (plus retention strobes
// when enabled).
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, forces OFF immediately
//   pg   : power_gate_ctrl_if.slave (requests in; ack, switch, clamp,
//          status and retention outputs)
// Parameters: N_SW header segments (>=1), STAGGER cycles between enables (>=1)
// Configuration macro: RETENTION_EN inserts RESTORE (power-up) and SAVE
// (power-down) states with their 1-cycle strobes.
// All outputs decode from the state register or sequencer flops.
// ----------------------------------------------------------------------------
module power_gate_ctrl
    import pg_pkg::*;
#(
    parameter int N_SW    = 4,
    parameter int STAGGER = 3
) (
    input  logic              clk,
    input  logic              rst,
    power_gate_ctrl_if.slave  pg
);

    pg_state_e       state;
    pg_state_e       next_state;
    logic            seq_start;
    logic            seq_off;
    logic            seq_done;
    logic [N_SW-1:0] sw_en_n;

    // State register; reset lands straight in OFF without a staggered shutdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= pg_state_e'(PG_OFF);
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Requests are only looked at in OFF and ON; a power-down
    // request wins in ON even if power-up is still asserted.
    always_comb begin
        next_state = state;
        case (state)
            ST_OFF: begin
                if (pg.pwr_up_req) begin
                    next_state = ST_PWR_UP;
                end
            end
            ST_PWR_UP: begin
                if (seq_done) begin
`ifdef RETENTION_EN
                    next_state = ST_RESTORE;
`else
                    next_state = ST_DEISO;
`endif
                end
            end
`ifdef RETENTION_EN
            ST_RESTORE: next_state = ST_DEISO;
            ST_SAVE:    next_state = ST_PWR_DN;
`endif
            ST_DEISO:   next_state = ST_ON;
            ST_ON: begin
                if (pg.pwr_down_req) begin
                    next_state = ST_ISO;
                end
            end
            ST_ISO: begin
`ifdef RETENTION_EN
                next_state = ST_SAVE;
`else
                next_state = ST_PWR_DN;
`endif
            end
            ST_PWR_DN:  next_state = ST_OFF;
            default:    next_state = ST_OFF;
        endcase
    end

    // The sequencer acts on the same edge as the state change so that the
    // first segment conducts in the first PWR_UP cycle and all segments open
    // in the first PWR_DN cycle.
    assign seq_start = (state == ST_OFF) && (next_state == ST_PWR_UP);
    assign seq_off   = (next_state == ST_PWR_DN);

    pg_stagger_seq #(
        .N_SW    (N_SW),
        .STAGGER (STAGGER)
    ) u_stagger (
        .clk     (clk),
        .rst     (rst),
        .start   (seq_start),
        .off     (seq_off),
        .sw_en_n (sw_en_n),
        .done    (seq_done)
    );

    assign pg.sw_en_n   = sw_en_n;
    assign pg.iso_en    = ~pg_iso_open(state);
    assign pg.pwr_ack   = (state == ST_DEISO) || (state == ST_PWR_DN);
    assign pg.domain_on = (state == pg_state_e'(PG_ON));
    assign pg.pg_state  = state;
`ifdef RETENTION_EN
    assign pg.ret_save    = (state == ST_SAVE);
    assign pg.ret_restore = (state == ST_RESTORE);
`endif

endmodule

// File: tb/tb_power_gate_ctrl.sv
// ----------------------------------------------------------------------------
// tb_power_gate_ctrl
// Scoreboard bench for power_gate_ctrl (N_SW=4, STAGGER=3). Stimulus pushes
// the hand-computed output changes it expects (cycle number plus full output
// vector) into a queue; a monitor samples on the falling edge and, whenever
// any output changes, pops and compares the next entry.
// Configuration macro: RETENTION_EN selects the retention-build expectations.
// ----------------------------------------------------------------------------
module tb_power_gate_ctrl;
    import pg_pkg::*;

    localparam int N_SW    = 4;
    localparam int STAGGER = 3;

    typedef struct {
        string      name;
        int         cyc;
        logic [3:0] sw;
        logic       iso;
        logic       ack;
        logic       on;
        logic [2:0] st;
        logic       rs;
        logic       rr;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst;
    int     cyc = 0;
    int     checks = 0;
    int     fails = 0;
    exp_t   exp_q[$];

    power_gate_ctrl_if #(.N_SW(N_SW)) pg_if ();

    power_gate_ctrl #(
        .N_SW    (N_SW),
        .STAGGER (STAGGER)
    ) dut (
        .clk (clk),
        .rst (rst),
        .pg  (pg_if)
    );

    always #5 clk = ~clk;

    // Cycle number = count of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic applyStimulus(input logic up, input logic down);
        pg_if.pwr_up_req   = up;
        pg_if.pwr_down_req = down;
    endtask

    task automatic pushExp(input string name, input int c, input logic [3:0] sw,
                           input logic iso, input logic ack, input logic on,
                           input logic [2:0] st, input logic rs = 1'b0,
                           input logic rr = 1'b0);
        exp_t e;
        e.name = name; e.cyc = c; e.sw = sw; e.iso = iso; e.ack = ack;
        e.on = on; e.st = st; e.rs = rs; e.rr = rr;
        exp_q.push_back(e);
    endtask

    // Request raised in cycle T: segment k at T+1+3k, then release of clamps.
    task automatic pushUp(input string tag, input int t);
        pushExp({tag, "_seg0"}, t + 1,  4'b1110, 1'b1, 1'b0, 1'b0, PG_ST_PWR_UP);
        pushExp({tag, "_seg1"}, t + 4,  4'b1100, 1'b1, 1'b0, 1'b0, PG_ST_PWR_UP);
        pushExp({tag, "_seg2"}, t + 7,  4'b1000, 1'b1, 1'b0, 1'b0, PG_ST_PWR_UP);
        pushExp({tag, "_seg3"}, t + 10, 4'b0000, 1'b1, 1'b0, 1'b0, PG_ST_PWR_UP);
`ifdef RETENTION_EN
        pushExp({tag, "_restore"}, t + 13, 4'b0000, 1'b1, 1'b0, 1'b0, PG_ST_RESTORE, 1'b0, 1'b1);
        pushExp({tag, "_deiso"}, t + 14, 4'b0000, 1'b0, 1'b1, 1'b0, PG_ST_DEISO);
        pushExp({tag, "_on"},    t + 15, 4'b0000, 1'b0, 1'b0, 1'b1, PG_ON);
`else
        pushExp({tag, "_deiso"}, t + 13, 4'b0000, 1'b0, 1'b1, 1'b0, PG_ST_DEISO);
        pushExp({tag, "_on"},    t + 14, 4'b0000, 1'b0, 1'b0, 1'b1, PG_ON);
`endif
    endtask

    task automatic pushDown(input string tag, input int t);
        pushExp({tag, "_iso"}, t + 1, 4'b0000, 1'b1, 1'b0, 1'b0, PG_ST_ISO);
`ifdef RETENTION_EN
        pushExp({tag, "_save"},  t + 2, 4'b0000, 1'b1, 1'b0, 1'b0, PG_ST_SAVE, 1'b1, 1'b0);
        pushExp({tag, "_pwrdn"}, t + 3, 4'b1111, 1'b1, 1'b1, 1'b0, PG_ST_PWR_DN);
        pushExp({tag, "_off"},   t + 4, 4'b1111, 1'b1, 1'b0, 1'b0, PG_OFF);
`else
        pushExp({tag, "_pwrdn"}, t + 2, 4'b1111, 1'b1, 1'b1, 1'b0, PG_ST_PWR_DN);
        pushExp({tag, "_off"},   t + 3, 4'b1111, 1'b1, 1'b0, 1'b0, PG_OFF);
`endif
    endtask

    // Bounded wait for the ack pulse; sits on the ack cycle when it returns.
    task automatic waitAck(input string tag);
        int n;
        n = 0;
        while (pg_if.pwr_ack !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            fails++;
            $display("[TB] FAIL %s_ack_timeout: got no pwr_ack, required pwr_ack within 40 cycles", tag);
        end
    endtask

    task automatic checkOutput(input logic [3:0] sw, input logic iso, input logic ack,
                               input logic on, input logic [2:0] st,
                               input logic rs, input logic rr);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("[TB] FAIL unexpected_change: got cyc=%0d sw=%b iso=%b ack=%b on=%b st=%0d rs=%b rr=%b, required no change",
                     cyc, sw, iso, ack, on, st, rs, rr);
        end else begin
            e = exp_q.pop_front();
            if (cyc != e.cyc || sw !== e.sw || iso !== e.iso || ack !== e.ack ||
                on !== e.on || st !== e.st || rs !== e.rs || rr !== e.rr) begin
                fails++;
                $display("[TB] FAIL %s: got cyc=%0d sw=%b iso=%b ack=%b on=%b st=%0d rs=%b rr=%b, required cyc=%0d sw=%b iso=%b ack=%b on=%b st=%0d rs=%b rr=%b",
                         e.name, cyc, sw, iso, ack, on, st, rs, rr,
                         e.cyc, e.sw, e.iso, e.ack, e.on, e.st, e.rs, e.rr);
            end
        end
    endtask

    // Monitor: any change of the sampled output vector is a DUT event.
    initial begin
        logic [12:0] prev;
        logic [12:0] obs;
        logic        rs;
        logic        rr;
        prev = 'x;
        forever begin
            @(negedge clk);
`ifdef RETENTION_EN
            rs = pg_if.ret_save;
            rr = pg_if.ret_restore;
`else
            rs = 1'b0;
            rr = 1'b0;
`endif
            obs = {pg_if.sw_en_n, pg_if.iso_en, pg_if.pwr_ack, pg_if.domain_on,
                   pg_if.pg_state, rs, rr};
            if (obs !== prev) begin
                checkOutput(pg_if.sw_en_n, pg_if.iso_en, pg_if.pwr_ack,
                            pg_if.domain_on, pg_if.pg_state, rs, rr);
            end
            prev = obs;
        end
    end

    initial begin
        int t;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        pushExp("reset", 1, 4'b1111, 1'b1, 1'b0, 1'b0, PG_OFF);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Plain power-up then power-down.
        t = cyc; pushUp("up1", t);
        applyStimulus(1'b1, 1'b0); waitAck("up1"); applyStimulus(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        t = cyc; pushDown("dn1", t);
        applyStimulus(1'b0, 1'b1); waitAck("dn1"); applyStimulus(1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // Both requests high in ON: down wins.
        t = cyc; pushUp("up2", t);
        applyStimulus(1'b1, 1'b0); waitAck("up2"); applyStimulus(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        t = cyc; pushDown("both", t);
        applyStimulus(1'b1, 1'b1); waitAck("both"); applyStimulus(1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // Down request during PWR_UP is ignored.
        t = cyc; pushUp("up3", t);
        applyStimulus(1'b1, 1'b0);
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 1'b0);
        waitAck("up3"); applyStimulus(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        t = cyc; pushDown("dn3", t);
        applyStimulus(1'b0, 1'b1); waitAck("dn3"); applyStimulus(1'b0, 1'b0);
        repeat (3) @(negedge clk);

        // Reset in cycle T+5 of a power-up: immediate return to OFF.
        t = cyc;
        pushExp("rstmid_seg0", t + 1, 4'b1110, 1'b1, 1'b0, 1'b0, PG_ST_PWR_UP);
        pushExp("rstmid_seg1", t + 4, 4'b1100, 1'b1, 1'b0, 1'b0, PG_ST_PWR_UP);
        pushExp("rstmid_off",  t + 5, 4'b1111, 1'b1, 1'b0, 1'b0, PG_OFF);
        applyStimulus(1'b1, 1'b0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Full cycle after the mid-sequence reset.
        t = cyc; pushUp("up4", t);
        applyStimulus(1'b1, 1'b0); waitAck("up4"); applyStimulus(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        t = cyc; pushDown("dn4", t);
        applyStimulus(1'b0, 1'b1); waitAck("dn4"); applyStimulus(1'b0, 1'b0);
        repeat (5) @(negedge clk);

        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            fails++;
            $display("[TB] FAIL %s: got no output change, required one at cyc=%0d", e.name, e.cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
